// File: rtl/instr_fetch_decode_pkg.sv
// Shared RV32 R-type encoding constants, ALU operation codes and fetch FSM states.
// The ALU imports this package too, so both sides agree on one code table.
package instr_fetch_decode_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE
  } state_e;

  // Sequential PC step; the 32-bit result wraps naturally at the top of memory.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
    return cur + XLEN'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory fetch bus: request/address out, data/valid pulse back.
interface instr_fetch_decode_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, addr, input rdata, rvalid);
  modport slave  (input req, addr, output rdata, rvalid);
endinterface

// File: rtl/instr_fetch_decode_r_type_decoder.sv
// Combinational R-type decoder: instruction word -> ALU code, legality and register fields.
module r_type_decoder
  import instr_fetch_decode_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  output alu_op_e          alu_control,
  output logic             legal,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_control = ALU_ADD;
          F3_SLL:     alu_control = ALU_SLL;
          F3_SLT:     alu_control = ALU_SLT;
          F3_SLTU:    alu_control = ALU_SLTU;
          F3_XOR:     alu_control = ALU_XOR;
          F3_SRL_SRA: alu_control = ALU_SRL;
          F3_OR:      alu_control = ALU_OR;
          F3_AND:     alu_control = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        // Only SUB and SRA use the alternate funct7 encoding.
        if (funct3 == F3_ADD_SUB) begin
          alu_control = ALU_SUB;
          legal       = 1'b1;
        end else if (funct3 == F3_SRL_SRA) begin
          alu_control = ALU_SRA;
          legal       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer: fetches one word per instruction, decodes R-type ops,
// and presents register fields, ALU code and one-cycle strobes to the datapath.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  instr_fetch_decode_if.master imem,
  output logic [REG_W-1:0]     read_reg_num1,
  output logic [REG_W-1:0]     read_reg_num2,
  output logic [REG_W-1:0]     write_reg,
  output logic [3:0]           alu_control,
  output logic                 regwrite,
  output logic                 illegal,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      retired
);

  state_e           state;
  alu_op_e          dec_alu;
  logic             dec_legal;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;

  // Decoding the returning word directly lets every ISSUE output be a plain register.
  r_type_decoder u_decoder (
    .instr       (imem.rdata),
    .alu_control (dec_alu),
    .legal       (dec_legal),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd)
  );

  assign imem.addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      retired       <= '0;
      imem.req      <= 1'b0;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg     <= '0;
      alu_control   <= ALU_AND;
      regwrite      <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem.req <= 1'b1;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // A response is only accepted here; stray pulses in other states fall through.
          if (imem.rvalid) begin
            state         <= ISSUE;
            imem.req      <= 1'b0;
            read_reg_num1 <= dec_rs1;
            read_reg_num2 <= dec_rs2;
            write_reg     <= dec_rd;
            regwrite      <= dec_legal && (dec_rd != '0);
            illegal       <= !dec_legal;
            if (dec_legal) begin
              alu_control <= dec_alu;
            end
          end
        end
        ISSUE: begin
          regwrite <= 1'b0;
          illegal  <= 1'b0;
          pc       <= next_pc(pc);
          retired  <= retired + XLEN'(1);
          if (run) begin
            state    <= FETCH;
            imem.req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imem.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed R-type/illegal words, variable memory latency,
// reset in mid-fetch with a stale response, and PC wrap on a second instance.
module tb_instr_fetch_decode;

  typedef struct {
    logic [31:0] word;
    int          rc;
  } mem_t;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw;
    logic        ill;
    int          rc;
    logic [31:0] pc_issue;
    logic [31:0] pc;
    logic [31:0] ret;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic run   = 1'b0;
  logic run2  = 1'b0;

  instr_fetch_decode_if imem ();
  instr_fetch_decode_if imem2 ();

  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu;
  logic        regwrite, illegal;
  logic [31:0] pc, retired;

  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [3:0]  alu_2;
  logic        regwrite_2, illegal_2;
  logic [31:0] pc_2, retired_2;

  instr_fetch_decode #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .imem          (imem),
    .read_reg_num1 (rs1),
    .read_reg_num2 (rs2),
    .write_reg     (rd),
    .alu_control   (alu),
    .regwrite      (regwrite),
    .illegal       (illegal),
    .pc            (pc),
    .retired       (retired)
  );

  instr_fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clock         (clock),
    .reset         (reset),
    .run           (run2),
    .imem          (imem2),
    .read_reg_num1 (rs1_2),
    .read_reg_num2 (rs2_2),
    .write_reg     (rd_2),
    .alu_control   (alu_2),
    .regwrite      (regwrite_2),
    .illegal       (illegal_2),
    .pc            (pc_2),
    .retired       (retired_2)
  );

  // Wrap instance sees a one-cycle memory: valid follows the request, ignored during FETCH.
  assign imem2.rvalid = imem2.req;
  assign imem2.rdata  = 32'h002081B3;

  always #5 clock = ~clock;

  int   tests  = 0;
  int   fails  = 0;
  int   rw_cnt = 0;
  int   ill_cnt = 0;
  mem_t mem_q[$];
  exp_t exp_q[$];
  logic [31:0] model_pc  = 32'h0;
  logic [31:0] model_ret = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},      {31'b0, imem.req}, 32'h0);
    chk({tag, "_pc"},       pc, 32'h0);
    chk({tag, "_retired"},  retired, 32'h0);
    chk({tag, "_alu"},      {28'b0, alu}, 32'h0);
    chk({tag, "_rs1"},      {27'b0, rs1}, 32'h0);
    chk({tag, "_rs2"},      {27'b0, rs2}, 32'h0);
    chk({tag, "_rd"},       {27'b0, rd}, 32'h0);
    chk({tag, "_regwrite"}, {31'b0, regwrite}, 32'h0);
    chk({tag, "_illegal"},  {31'b0, illegal}, 32'h0);
  endtask

  // Memory model: respond in the rc-th cycle of an outstanding request.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      imem.rvalid = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else if (imem.req && mem_q.size() > 0) begin
        cnt++;
        if (cnt == mem_q[0].rc) begin
          imem.rdata  = mem_q[0].word;
          imem.rvalid = 1'b1;
          void'(mem_q.pop_front());
          cnt = 0;
        end
      end
    end
  end

  // Strobe counters over the whole run.
  initial begin
    forever begin
      @(negedge clock);
      if (regwrite) rw_cnt++;
      if (illegal)  ill_cnt++;
    end
  end

  // Monitor: a response accepted in WAIT means the next cycle is ISSUE.
  initial begin
    int   req_run;
    int   rc_seen;
    exp_t e;
    req_run = 0;
    forever begin
      @(negedge clock);
      if (imem.req) req_run++;
      else          req_run = 0;
      if (reset && imem.req && imem.rvalid) begin
        rc_seen = req_run;
        @(negedge clock);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got an issue, expected none pending");
        end else begin
          e = exp_q.pop_front();
          chk("rs1",        {27'b0, rs1}, {27'b0, e.rs1});
          chk("rs2",        {27'b0, rs2}, {27'b0, e.rs2});
          chk("rd",         {27'b0, rd},  {27'b0, e.rd});
          chk("alu",        {28'b0, alu}, {28'b0, e.alu});
          chk("regwrite",   {31'b0, regwrite}, {31'b0, e.rw});
          chk("illegal",    {31'b0, illegal},  {31'b0, e.ill});
          chk("req_cycles", rc_seen, e.rc);
          chk("issue_pc",   pc, e.pc_issue);
          chk("issue_addr", imem.addr, e.pc_issue);
          @(negedge clock);
          req_run = imem.req ? 1 : 0;
          chk("pc_next",      pc, e.pc);
          chk("retired_next", retired, e.ret);
          chk("regwrite_off", {31'b0, regwrite}, 32'h0);
          chk("illegal_off",  {31'b0, illegal},  32'h0);
        end
      end
    end
  end

  task automatic exec(input logic [31:0] word, input int rc,
                      input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                      input logic [3:0] e_alu, input logic e_rw, input logic e_ill);
    mem_t m;
    exp_t e;
    bit   seen;
    m.word = word;
    m.rc   = rc;
    mem_q.push_back(m);
    e.rs1 = e_rs1; e.rs2 = e_rs2; e.rd = e_rd; e.alu = e_alu;
    e.rw = e_rw; e.ill = e_ill; e.rc = rc;
    e.pc_issue = model_pc;
    e.pc  = model_pc + 32'd4;
    e.ret = model_ret + 32'd1;
    exp_q.push_back(e);
    model_pc  = model_pc + 32'd4;
    model_ret = model_ret + 32'd1;
    @(negedge clock);
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = imem.req;
    end
    if (!seen) timeout("fetch_req");
    // Dropping run in FETCH must still let this instruction complete.
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = (retired == model_ret);
    end
    if (!seen) timeout("retire");
    repeat (2) @(negedge clock);
  endtask

  initial begin
    bit seen;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    repeat (3) @(negedge clock);
    chk_reset("por");
    reset = 1'b1;

    //   word          rc  rs1 rs2 rd  alu      rw  ill
    exec(32'h002081B3, 2,  1,  2,  3,  4'b0010, 1, 0);  // add x3,x1,x2
    exec(32'h407302B3, 3,  6,  7,  5,  4'b0110, 1, 0);  // sub x5,x6,x7
    exec(32'h00000013, 2,  0,  0,  0,  4'b0110, 0, 1);  // I-type: alu holds
    exec(32'h00208033, 2,  1,  2,  0,  4'b0010, 0, 0);  // add x0,x1,x2
    exec(32'h40C5D533, 5, 11, 12, 10,  4'b0111, 1, 0);  // sra x10,x11,x12
    exec(32'h01DF7FB3, 2, 30, 29, 31,  4'b0000, 1, 0);  // and x31,x30,x29
    exec(32'h40001033, 4,  0,  0,  0,  4'b0000, 0, 1);  // funct7 0x20 with sll
    exec(32'h003130B3, 2,  2,  3,  1,  4'b1001, 1, 0);  // sltu x1,x2,x3
    chk("regwrite_pulses", rw_cnt, 5);
    chk("illegal_pulses",  ill_cnt, 2);

    // Reset in the middle of WAIT, then a stale response after release.
    @(negedge clock);
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = imem.req;
    end
    if (!seen) timeout("wait_req");
    run = 1'b0;
    repeat (2) @(negedge clock);
    chk("in_wait_req", {31'b0, imem.req}, 32'h1);
    reset = 1'b0;
    #1;
    chk_reset("mid_wait");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;
    imem.rdata  = 32'h002081B3;
    imem.rvalid = 1'b1;
    repeat (4) @(negedge clock);
    chk("stale_req",      {31'b0, imem.req}, 32'h0);
    chk("stale_pc",       pc, 32'h0);
    chk("stale_retired",  retired, 32'h0);
    chk("stale_regwrite", rw_cnt, 5);
    model_pc  = 32'h0;
    model_ret = 32'h0;
    exec(32'h002081B3, 2, 1, 2, 3, 4'b0010, 1, 0);

    // PC wrap from 0xFFFF_FFFC.
    @(negedge clock);
    run2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = imem2.req;
    end
    if (!seen) timeout("wrap_req");
    run2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = (retired_2 == 32'd1);
    end
    if (!seen) timeout("wrap_retire");
    chk("wrap_pc",      pc_2, 32'h0000_0000);
    chk("wrap_retired", retired_2, 32'd1);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Port clock, input, 1: single clock; all state on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port run, input, 1: level; 1 permits new fetches, 0 parks the block after the current instruction completes.
REQ-005 Port imem_req, output, 1: fetch request, held until imem_rvalid.
REQ-006 Port imem_addr, output, 32: byte address of the fetch, equal to the PC.
REQ-007 Port imem_rdata, input, 32: instruction word, valid only when imem_rvalid=1.
REQ-008 Port imem_rvalid, input, 1: one-cycle pulse; latency is 1..N cycles after the request.
REQ-009 Port read_reg_num1 / read_reg_num2 / write_reg, output, 5 each: rs1 / rs2 / rd fields for the datapath.
REQ-010 Port alu_control, output, 4: ALU operation code.
REQ-011 Port regwrite, output, 1: one-cycle write strobe to the datapath.
REQ-012 Port illegal, output, 1: one-cycle pulse on an unsupported instruction.
REQ-013 Port pc, output, 32: current PC.
REQ-014 Port retired, output, 32: count of instructions issued, legal or illegal.

Function
REQ-015 FSM states: IDLE, FETCH, WAIT, ISSUE.
- IDLE -> FETCH when run=1.
- FETCH asserts imem_req and goes to WAIT on the next cycle.
- WAIT keeps imem_req=1 and captures imem_rdata into the instruction register when imem_rvalid=1, then goes to ISSUE.
- ISSUE lasts exactly one cycle, then goes to FETCH if run=1, otherwise IDLE.
REQ-016 imem_req SHALL be 1 only in FETCH and WAIT; imem_addr SHALL equal pc at all times.
REQ-017 imem_rvalid in any state other than WAIT SHALL be ignored.
REQ-018 Field extraction from the captured word:
- read_reg_num1 = [19:15]
- read_reg_num2 = [24:20]
- write_reg = [11:7]
- These are registered and held stable from ISSUE until the next capture.
REQ-019 Legal instruction: opcode [6:0]=7'b0110011, with funct7 0x00 (any funct3), or funct7 0x20 with funct3 000 or 101.
REQ-020 alu_control mapping (funct7/funct3 -> code):
- ADD 0010, SUB 0110, SLL 0100, SLT 1000, SLTU 1001
- XOR 0011, SRL 0101, SRA 0111, OR 0001, AND 0000
REQ-021 regwrite SHALL be 1 only during ISSUE, and only for a legal instruction with write_reg != 0.
REQ-022 illegal SHALL pulse during ISSUE for an illegal word; regwrite stays 0 and alu_control holds its previous value.
REQ-023 On leaving ISSUE: pc <= pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000) and retired <= retired+1 (wraps).
REQ-024 run deasserting during FETCH or WAIT SHALL NOT abort the fetch; the instruction is issued, then the FSM enters IDLE.

Reset
REQ-025 Asserting reset in any state, including mid-WAIT, SHALL immediately force:
- state IDLE
- pc = RESET_PC, retired = 0
- instruction register = 0, all register fields = 0, alu_control = 0000
- regwrite = 0, illegal = 0, imem_req = 0
REQ-026 A response arriving after reset deassertion to a request made before reset SHALL be ignored.

Structure
REQ-027 Opcode, funct7 and funct3 constants and the ALU code table SHALL reside in a shared package also used by the ALU.
REQ-028 One sub-module, r_type_decoder: purely combinational, instruction word -> {alu_control, legal}.

Verification
REQ-029 Reset release, run=1, 1-cycle memory returning 0x002081B3 (add x3,x1,x2) -> ISSUE shows rs1=1, rs2=2, rd=3, alu_control=0010, regwrite=1; then pc=4, retired=1.
REQ-030 Word 0x407302B3 (sub x5,x6,x7) with 3-cycle latency -> imem_req held 3 cycles, one regwrite pulse, alu_control=0110, write_reg=5.
REQ-031 Word 0x00000013 (I-type) -> illegal=1 for one cycle, regwrite=0, pc advances by 4.
REQ-032 Word 0x00208033 (add x0,x1,x2) -> regwrite=0, illegal=0, retired increments.
REQ-033 RESET_PC=0xFFFF_FFFC, one instruction issued -> pc=0x0000_0000.
REQ-034 Reset asserted mid-WAIT, then an imem_rvalid pulse after release -> block in IDLE or FETCH with pc=RESET_PC and no regwrite from the stale response.
